// File: rtl/delaygate_sweep_ctrl_if.sv
// delaygate_sweep_ctrl_if
// Bundles the sweep controller's start handshake, gate drive/observe lines and
// sweep report.  The master side is the sweep controller; the slave side is the
// gate plus whoever starts sweeps and reads back the report.
// Optional macro: DELAYGATE_SWEEP_FIRSTFAIL_EN adds fail_valid / fail_vec.
`timescale 1ns/1ps

interface delaygate_sweep_ctrl_if;

    // Handshake
    logic       start;
    logic       busy;
    logic       done;

    // Gate drive and observation
    logic       a;
    logic       b;
    logic       c;
    logic       y;

    // Sweep report
    logic [7:0] result;
    logic [3:0] err_count;
    logic       pass;

`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
    logic       fail_valid;
    logic [2:0] fail_vec;

    modport master (
        input  start,
        input  y,
        output a,
        output b,
        output c,
        output busy,
        output done,
        output result,
        output err_count,
        output pass,
        output fail_valid,
        output fail_vec
    );

    modport slave (
        output start,
        output y,
        input  a,
        input  b,
        input  c,
        input  busy,
        input  done,
        input  result,
        input  err_count,
        input  pass,
        input  fail_valid,
        input  fail_vec
    );
`else
    modport master (
        input  start,
        input  y,
        output a,
        output b,
        output c,
        output busy,
        output done,
        output result,
        output err_count,
        output pass
    );

    modport slave (
        output start,
        output y,
        input  a,
        input  b,
        input  c,
        input  busy,
        input  done,
        input  result,
        input  err_count,
        input  pass
    );
`endif

endinterface

// File: rtl/delaygate_sweep_ctrl.sv
// delaygate_sweep_ctrl
// Walks the 3-input delay gate through all eight input vectors {a,b,c} = 0..7,
// lets each vector settle for SETTLE_CYCLES clocks, samples y, and compares the
// captured pattern against the golden truth table EXPECTED.  The gate inputs
// come straight from flops so they never glitch while a vector is settling.
// Optional macro: DELAYGATE_SWEEP_FIRSTFAIL_EN records the index of the first
// mismatching vector of each sweep (fail_valid / fail_vec).
`timescale 1ns/1ps

module delaygate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 7,
    parameter logic [7:0]  EXPECTED      = 8'b00110001
) (
    input  logic                   clk,
    input  logic                   reset,
    delaygate_sweep_ctrl_if.master sweep
);

    // The settle counter is 4 bits wide, so only 1..15 settle cycles fit.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("delaygate_sweep_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC    = 3'd7;

    state_t     state_q,    state_d;
    logic [2:0] vec_q,      vec_d;
    logic [3:0] settle_q,   settle_d;
    logic [2:0] abc_q,      abc_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic [7:0] result_q,   result_d;
    logic [3:0] err_q,      err_d;
    logic       pass_q,     pass_d;
    logic       mismatch;

`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
    logic       fail_valid_q, fail_valid_d;
    logic [2:0] fail_vec_q,   fail_vec_d;
`endif

    // y disagrees with the golden response for the vector currently applied.
    assign mismatch = (sweep.y != EXPECTED[vec_q]);

    // Next-state logic: everything holds by default, done is a one-cycle pulse.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        abc_d    = abc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        err_d    = err_q;
        pass_d   = pass_q;
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
`endif

        case (state_q)
            IDLE: begin
                // Accepting a start wipes the previous report and drives vector 0.
                if (sweep.start) begin
                    state_d  = SETTLE;
                    vec_d    = 3'd0;
                    abc_d    = 3'd0;
                    busy_d   = 1'b1;
                    settle_d = 4'd0;
                    result_d = 8'h00;
                    err_d    = 4'd0;
                    pass_d   = 1'b0;
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 3'd0;
`endif
                end
            end

            SETTLE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                result_d[vec_q] = sweep.y;
                // Eight vectors at most, so the 4-bit count cannot wrap.
                if (mismatch) begin
                    err_d = err_q + 4'd1;
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
`endif
                end

                if (vec_q == LAST_VEC) begin
                    // Last vector: report in the DONE cycle, inputs stay at 7.
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d  = SETTLE;
                    vec_d    = vec_q + 3'd1;
                    abc_d    = vec_q + 3'd1;
                    settle_d = 4'd0;
                end
            end

            DONE: begin
                // start is deliberately not looked at here; it re-arms from IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            vec_q    <= 3'd0;
            settle_q <= 4'd0;
            abc_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            err_q    <= 4'd0;
            pass_q   <= 1'b0;
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            abc_q    <= abc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
`endif
        end
    end

    assign sweep.a         = abc_q[2];
    assign sweep.b         = abc_q[1];
    assign sweep.c         = abc_q[0];
    assign sweep.busy      = busy_q;
    assign sweep.done      = done_q;
    assign sweep.result    = result_q;
    assign sweep.err_count = err_q;
    assign sweep.pass      = pass_q;
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
    assign sweep.fail_valid = fail_valid_q;
    assign sweep.fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_delaygate_sweep_ctrl.sv
// tb_delaygate_sweep_ctrl
// Two controllers side by side: dut0 with the default 7-cycle settle and dut1
// with a 1-cycle settle.  Each drives its own gate model, a truth table seen
// through a delay line as long as the settle interval.  Expected reports are
// computed from the truth table alone (captured pattern = table, errors =
// differing bits against the golden response, cadence = SETTLE_CYCLES+1).
// Honours DELAYGATE_SWEEP_FIRSTFAIL_EN when defined.
`timescale 1ns/1ps

module tb_delaygate_sweep_ctrl;

    localparam int         S0     = 7;
    localparam int         S1     = 1;
    localparam logic [7:0] GOLDEN = 8'b00110001;

    logic clk = 1'b0;
    logic reset;

    int vectorsApplied = 0;
    int miscompares    = 0;

    logic [7:0] tbl0 = 8'h00;
    logic [7:0] tbl1 = 8'h00;
    logic [7:0] lastTbl [2];
    logic [7:0] realTbl;

    logic [2:0] hist0 [16] = '{default: 3'b000};
    logic [2:0] hist1 [16] = '{default: 3'b000};

    delaygate_sweep_ctrl_if bus0 ();
    delaygate_sweep_ctrl_if bus1 ();

    delaygate_sweep_ctrl #(.SETTLE_CYCLES(S0), .EXPECTED(GOLDEN)) dut0 (
        .clk   (clk),
        .reset (reset),
        .sweep (bus0)
    );

    delaygate_sweep_ctrl #(.SETTLE_CYCLES(S1), .EXPECTED(GOLDEN)) dut1 (
        .clk   (clk),
        .reset (reset),
        .sweep (bus1)
    );

    always #5 clk = ~clk;

    // Gate models: output follows the truth table of the inputs S cycles ago.
    always @(posedge clk) begin
        hist0[0] <= {bus0.a, bus0.b, bus0.c};
        hist1[0] <= {bus1.a, bus1.b, bus1.c};
        for (int i = 1; i < 16; i++) begin
            hist0[i] <= hist0[i-1];
            hist1[i] <= hist1[i-1];
        end
    end

    assign bus0.y = tbl0[hist0[S0-1]];
    assign bus1.y = tbl1[hist1[S1-1]];

    function automatic int settleOf(input int sel);
        return (sel != 0) ? S1 : S0;
    endfunction

    function automatic logic [2:0] abcOf(input int sel);
        return (sel != 0) ? {bus1.a, bus1.b, bus1.c} : {bus0.a, bus0.b, bus0.c};
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel != 0) ? bus1.busy : bus0.busy;
    endfunction

    function automatic logic doneOf(input int sel);
        return (sel != 0) ? bus1.done : bus0.done;
    endfunction

    function automatic logic passOf(input int sel);
        return (sel != 0) ? bus1.pass : bus0.pass;
    endfunction

    function automatic logic [7:0] resultOf(input int sel);
        return (sel != 0) ? bus1.result : bus0.result;
    endfunction

    function automatic logic [3:0] errOf(input int sel);
        return (sel != 0) ? bus1.err_count : bus0.err_count;
    endfunction

`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
    function automatic logic failValidOf(input int sel);
        return (sel != 0) ? bus1.fail_valid : bus0.fail_valid;
    endfunction

    function automatic logic [2:0] failVecOf(input int sel);
        return (sel != 0) ? bus1.fail_vec : bus0.fail_vec;
    endfunction
`endif

    // Lowest vector index whose table bit differs from the golden response.
    function automatic logic [2:0] firstFail(input logic [7:0] tbl);
        logic [7:0] diff;
        diff = tbl ^ GOLDEN;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) firstFail = 3'(i);
        end
        if (diff == 8'h00) firstFail = 3'd0;
    endfunction

    // Truth table of y = ~b & (a | ~c), bit i for {a,b,c} = i.
    function automatic logic [7:0] gateTruth();
        logic [7:0] t;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            t[i] = ~v[1] & (v[2] | ~v[0]);
        end
        return t;
    endfunction

    task automatic setStart(input int sel, input logic v);
        if (sel != 0) bus1.start = v;
        else          bus0.start = v;
    endtask

    task automatic setTable(input int sel, input logic [7:0] t);
        if (sel != 0) tbl1 = t;
        else          tbl0 = t;
    endtask

    // One sweep with per-cycle checking.  pokeCycle pulses start during the
    // sweep (must be ignored); holdStart leaves start high at the end.
    task automatic run_sweep(input int sel, input logic [7:0] tbl, input int pokeCycle,
                             input bit holdStart, input bit alreadyStarted);
        int         per;
        int         total;
        int         k;
        int         lastN;
        logic [7:0] mask;
        logic [7:0] wantResult;
        logic [3:0] wantErr;
        logic       wantPass;
        per   = settleOf(sel) + 1;
        total = 8 * per;
        lastN = holdStart ? total + 1 : total + 2;
        setTable(sel, tbl);
        if (!alreadyStarted) begin
            @(negedge clk);
            vectorsApplied++;
            if (busyOf(sel) !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_busy sel=%0d got=%b want=0", sel, busyOf(sel));
            end
            setStart(sel, 1'b1);
            @(posedge clk);
        end
        for (int n = 0; n <= lastN; n++) begin
            @(negedge clk);
            k = n / per;
            if (k > 8) k = 8;
            mask = 8'h00;
            for (int i = 0; i < k; i++) mask[i] = 1'b1;
            wantResult = tbl & mask;
            wantErr    = 4'($countones((tbl ^ GOLDEN) & mask));
            wantPass   = (n >= total) && ((tbl ^ GOLDEN) == 8'h00);

            vectorsApplied++;
            if (busyOf(sel) !== (n < total)) begin
                miscompares++;
                $display("[TB] FAIL busy sel=%0d n=%0d got=%b want=%b", sel, n, busyOf(sel), n < total);
            end
            vectorsApplied++;
            if (doneOf(sel) !== (n == total)) begin
                miscompares++;
                $display("[TB] FAIL done sel=%0d n=%0d got=%b want=%b", sel, n, doneOf(sel), n == total);
            end
            if (n < total) begin
                vectorsApplied++;
                if (abcOf(sel) !== 3'(n / per)) begin
                    miscompares++;
                    $display("[TB] FAIL abc sel=%0d n=%0d got=%0d want=%0d", sel, n, abcOf(sel), n / per);
                end
            end
            vectorsApplied++;
            if (resultOf(sel) !== wantResult) begin
                miscompares++;
                $display("[TB] FAIL result sel=%0d n=%0d got=%h want=%h", sel, n, resultOf(sel), wantResult);
            end
            vectorsApplied++;
            if (errOf(sel) !== wantErr) begin
                miscompares++;
                $display("[TB] FAIL err_count sel=%0d n=%0d got=%0d want=%0d", sel, n, errOf(sel), wantErr);
            end
            vectorsApplied++;
            if (passOf(sel) !== wantPass) begin
                miscompares++;
                $display("[TB] FAIL pass sel=%0d n=%0d got=%b want=%b", sel, n, passOf(sel), wantPass);
            end
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
            if (n == 0 || n >= total) begin
                vectorsApplied++;
                if (failValidOf(sel) !== ((n >= total) && ((tbl ^ GOLDEN) != 8'h00))) begin
                    miscompares++;
                    $display("[TB] FAIL fail_valid sel=%0d n=%0d got=%b", sel, n, failValidOf(sel));
                end
                vectorsApplied++;
                if (failVecOf(sel) !== ((n >= total) ? firstFail(tbl) : 3'd0)) begin
                    miscompares++;
                    $display("[TB] FAIL fail_vec sel=%0d n=%0d got=%0d want=%0d", sel, n,
                             failVecOf(sel), (n >= total) ? firstFail(tbl) : 3'd0);
                end
            end
`endif
            if (holdStart) setStart(sel, 1'b1);
            else           setStart(sel, (n == pokeCycle) ? 1'b1 : 1'b0);
        end
        lastTbl[sel] = tbl;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            vectorsApplied++;
            if ({abcOf(sel), busyOf(sel), doneOf(sel), resultOf(sel), errOf(sel), passOf(sel)} !== 17'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_values sel=%0d got abc=%0d busy=%b done=%b result=%h err=%0d pass=%b want all 0",
                         sel, abcOf(sel), busyOf(sel), doneOf(sel), resultOf(sel), errOf(sel), passOf(sel));
            end
`ifdef DELAYGATE_SWEEP_FIRSTFAIL_EN
            vectorsApplied++;
            if ({failValidOf(sel), failVecOf(sel)} !== 4'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_firstfail sel=%0d got valid=%b vec=%0d want 0", sel, failValidOf(sel), failVecOf(sel));
            end
`endif
        end
        reset = 1'b0;
    endtask

    task automatic test_real_gate();
        run_sweep(0, realTbl, 20, 1'b0, 1'b0);
    endtask

    task automatic test_force_low();
        run_sweep(0, 8'h00, -1, 1'b0, 1'b0);
    endtask

    task automatic test_force_high_fast();
        run_sweep(1, 8'hFF, -1, 1'b0, 1'b0);
    endtask

    task automatic test_start_during_done();
        logic [7:0] t;
        t = 8'($urandom);
        run_sweep(0, t, 8 * (S0 + 1), 1'b0, 1'b0);
    endtask

    task automatic test_hold_idle();
        int waitCycles;
        waitCycles = $urandom_range(5, 15);
        for (int n = 0; n < waitCycles; n++) begin
            @(negedge clk);
            vectorsApplied++;
            if (resultOf(0) !== lastTbl[0] || errOf(0) !== 4'($countones(lastTbl[0] ^ GOLDEN)) ||
                passOf(0) !== (lastTbl[0] == GOLDEN) || busyOf(0) !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_hold n=%0d got result=%h err=%0d pass=%b busy=%b want result=%h",
                         n, resultOf(0), errOf(0), passOf(0), busyOf(0), lastTbl[0]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic sawActivity;
        setTable(0, realTbl);
        @(negedge clk);
        setStart(0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        setStart(0, 1'b0);
        repeat (4 * (S0 + 1) + 2) @(negedge clk);
        vectorsApplied++;
        if (abcOf(0) !== 3'd4 || busyOf(0) !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_vec got abc=%0d busy=%b want abc=4 busy=1", abcOf(0), busyOf(0));
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectorsApplied++;
        if ({abcOf(0), busyOf(0), doneOf(0), resultOf(0), errOf(0), passOf(0)} !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_values got abc=%0d busy=%b done=%b result=%h err=%0d pass=%b want all 0",
                     abcOf(0), busyOf(0), doneOf(0), resultOf(0), errOf(0), passOf(0));
        end
        sawActivity = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (doneOf(0) !== 1'b0 || busyOf(0) !== 1'b0) sawActivity = 1'b1;
        end
        vectorsApplied++;
        if (sawActivity !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL no_done_after_reset got activity=%b want 0", sawActivity);
        end
        run_sweep(0, realTbl, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta;
        logic [7:0] tb;
        ta = 8'($urandom);
        tb = 8'($urandom);
        run_sweep(1, ta, -1, 1'b1, 1'b0);
        @(posedge clk);
        run_sweep(1, tb, -1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int sel;
        int poke;
        logic [7:0] t;
        for (int r = 0; r < 6; r++) begin
            sel  = int'($urandom_range(0, 1));
            t    = 8'($urandom);
            poke = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 8 * (settleOf(sel) + 1)));
            run_sweep(sel, t, poke, 1'b0, 1'b0);
        end
    endtask

    // Backstop so the run always ends even if the design locks up.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout got=running want=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset      = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        realTbl    = gateTruth();
        repeat (4) @(posedge clk);
        test_reset();
        test_real_gate();
        test_force_low();
        test_force_high_fast();
        test_start_during_done();
        test_hold_idle();
        test_reset_mid_sweep();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
